door_input_conditioner: RTL and testbench

Front-end stage feeding the automatic door motor controller. It synchronises and debounces the raw push-button, limit-switch and obstruction inputs. It produces clean UP_Max and DN_Max levels and a single-cycle Activate pulse, generated from a button press or from an auto-close hold timer. It also flags an impossible limit-switch combination and blocks Activate while that condition or an obstruction is present.

---
 rtl/door_input_conditioner.sv | 139 +++++++++++++
 tb/tb_door_input_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/door_input_conditioner.sv
// Input front end for the door motor controller: synchronise and debounce the raw inputs,
// then generate the Activate pulse from a button press or from the auto-close hold timer.
module door_input_conditioner #(
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned TMR_W       = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_RAW,
    input  logic UP_SW_RAW,
    input  logic DN_SW_RAW,
    input  logic OBST_RAW,
    input  logic AUTO_EN,
    output logic Activate,
    output logic UP_Max,
    output logic DN_Max,
    output logic LIM_FAULT,
    output logic HOLD_BUSY
);

    localparam int unsigned DbW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
    localparam logic [DbW-1:0]   DbOne    = DbW'(1);
    localparam logic [TMR_W-1:0] HoldLoad = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TmrOne   = TMR_W'(1);

    typedef enum logic [1:0] {StWaitOpen, StHolding, StWaitLeave} state_e;

    // Bit order for all per-input vectors: {obst, dn, up, btn}
    logic [3:0]          raw;
    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          db_q, db_d;
    logic [3:0][DbW-1:0] db_cnt_q, db_cnt_d;

    logic             btn_prev_q;
    logic             btn_edge;
    logic             db_btn, db_obst, up_max, dn_max, lim_fault;
    state_e           state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             auto_fire;
    logic             activate_q, activate_d;

    assign raw = {OBST_RAW, DN_SW_RAW, UP_SW_RAW, BTN_RAW};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // A new level must persist DB_CYCLES synchronised cycles before db follows it.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbOne;
                end
            end
        end
    end

    assign db_btn    = db_q[0];
    assign up_max    = db_q[1];
    assign dn_max    = db_q[2];
    assign db_obst   = db_q[3];
    assign lim_fault = up_max & dn_max;
    assign btn_edge  = db_btn & ~btn_prev_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            btn_prev_q <= 1'b0;
            state_q    <= StWaitOpen;
            cnt_q      <= '0;
            activate_q <= 1'b0;
        end else begin
            btn_prev_q <= db_btn;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            activate_q <= activate_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        auto_fire = 1'b0;
        unique case (state_q)
            StWaitOpen: begin
                if (AUTO_EN && up_max && !dn_max) begin
                    state_d = StHolding;
                    cnt_d   = HoldLoad;
                end
            end
            StHolding: begin
                if (!AUTO_EN || !up_max || lim_fault) begin
                    state_d = StWaitOpen;
                end else if (btn_edge) begin
                    state_d = StWaitLeave;
                end else if (db_obst) begin
                    cnt_d = HoldLoad;
                end else if (cnt_q == '0) begin
                    auto_fire = 1'b1;
                    state_d   = StWaitLeave;
                end else begin
                    cnt_d = cnt_q - TmrOne;
                end
            end
            StWaitLeave: begin
                // One auto pulse per opening; re-arm only once the door leaves the open limit.
                if (!up_max || !AUTO_EN) begin
                    state_d = StWaitOpen;
                end
            end
            default: state_d = StWaitOpen;
        endcase
    end

    assign activate_d = (btn_edge | auto_fire) & ~lim_fault & ~db_obst;

    assign Activate  = activate_q;
    assign UP_Max    = up_max;
    assign DN_Max    = dn_max;
    assign LIM_FAULT = lim_fault;
    assign HOLD_BUSY = (state_q == StHolding);

endmodule

// File: tb/tb_door_input_conditioner.sv
// Directed bench for door_input_conditioner; inputs change 1 time unit after a rising edge,
// outputs are checked at the same point, so "edge N" means the Nth rising edge after a change.
module tb_door_input_conditioner;

    logic CLK = 1'b0;
    logic RST;
    logic BTN_RAW, UP_SW_RAW, DN_SW_RAW, OBST_RAW, AUTO_EN;
    logic Activate, UP_Max, DN_Max, LIM_FAULT, HOLD_BUSY;

    int checks = 0;
    int errors = 0;
    int act_cnt = 0;
    int base;
    int busy_cnt;
    logic seen;

    door_input_conditioner #(
        .DB_CYCLES  (4),
        .HOLD_CYCLES(16),
        .TMR_W      (16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_RAW  (BTN_RAW),
        .UP_SW_RAW(UP_SW_RAW),
        .DN_SW_RAW(DN_SW_RAW),
        .OBST_RAW (OBST_RAW),
        .AUTO_EN  (AUTO_EN),
        .Activate (Activate),
        .UP_Max   (UP_Max),
        .DN_Max   (DN_Max),
        .LIM_FAULT(LIM_FAULT),
        .HOLD_BUSY(HOLD_BUSY)
    );

    always #5 CLK = ~CLK;

    // Counts Activate pulses; each pulse is one cycle wide so it is seen on exactly one negedge.
    always @(negedge CLK) begin
        if (Activate === 1'b1) act_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        // 1: reset with every raw input high
        RST = 1'b0; BTN_RAW = 1'b1; UP_SW_RAW = 1'b1; DN_SW_RAW = 1'b1; OBST_RAW = 1'b1;
        AUTO_EN = 1'b0;
        base = act_cnt;
        tick(20);
        check_eq("rst_activate", Activate, 0);
        check_eq("rst_up_max", UP_Max, 0);
        check_eq("rst_dn_max", DN_Max, 0);
        check_eq("rst_lim_fault", LIM_FAULT, 0);
        check_eq("rst_hold_busy", HOLD_BUSY, 0);
        RST = 1'b1;
        tick(5);
        check_eq("rel_up_edge5", UP_Max, 0);
        tick(1);
        check_eq("rel_up_edge6", UP_Max, 1);
        check_eq("rel_dn_edge6", DN_Max, 1);
        check_eq("rel_lim_edge6", LIM_FAULT, 1);
        tick(6);
        check_eq("rel_no_activate", act_cnt - base, 0);
        BTN_RAW = 1'b0; UP_SW_RAW = 1'b0; DN_SW_RAW = 1'b0; OBST_RAW = 1'b0;
        tick(10);
        check_eq("clear_lim", LIM_FAULT, 0);

        // 2: short glitch rejected, long pulse qualified
        seen = 1'b0;
        UP_SW_RAW = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(1); seen |= UP_Max; end
        UP_SW_RAW = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(1); seen |= UP_Max; end
        check_eq("glitch3_rejected", seen, 0);
        UP_SW_RAW = 1'b1;
        tick(5);
        check_eq("up10_edge5", UP_Max, 0);
        tick(1);
        check_eq("up10_edge6", UP_Max, 1);
        tick(4);
        UP_SW_RAW = 1'b0;
        tick(5);
        check_eq("upfall_edge5", UP_Max, 1);
        tick(1);
        check_eq("upfall_edge6", UP_Max, 0);
        tick(5);

        // 3: bouncing button then long hold gives one pulse, 7 edges after the stable sample
        base = act_cnt;
        BTN_RAW = 1'b1; tick(1); BTN_RAW = 1'b0; tick(1);
        BTN_RAW = 1'b1; tick(1); BTN_RAW = 1'b0; tick(1);
        BTN_RAW = 1'b1;
        tick(6);
        check_eq("btn_edge6_none", act_cnt - base, 0);
        tick(1);
        check_eq("btn_edge7_activate", Activate, 1);
        tick(1);
        check_eq("btn_pulse_width", Activate, 0);
        tick(42);
        BTN_RAW = 1'b0;
        tick(10);
        check_eq("btn_one_pulse", act_cnt - base, 1);

        // 4: auto-close after the hold time
        base = act_cnt;
        AUTO_EN = 1'b1; UP_SW_RAW = 1'b1;
        tick(6);
        check_eq("auto_up_rise", UP_Max, 1);
        check_eq("auto_busy_at_rise", HOLD_BUSY, 0);
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin tick(1); if (HOLD_BUSY) busy_cnt++; end
        check_eq("auto_busy_16", busy_cnt, 16);
        check_eq("auto_no_early", act_cnt - base, 0);
        tick(1);
        check_eq("auto_activate_e17", Activate, 1);
        check_eq("auto_busy_done", HOLD_BUSY, 0);
        tick(40);
        check_eq("auto_single", act_cnt - base, 1);
        UP_SW_RAW = 1'b0;
        tick(8);

        // 5: obstruction reloads the hold timer, then blocks a button press
        base = act_cnt;
        UP_SW_RAW = 1'b1;
        tick(6);
        check_eq("obst_up_rise", UP_Max, 1);
        tick(5);
        OBST_RAW = 1'b1;
        tick(10);
        OBST_RAW = 1'b0;
        // db_obst drops at E+21 and reloads there, so the timer fires 16 edges later
        tick(21);
        check_eq("obst_no_early", act_cnt - base, 0);
        check_eq("obst_busy_e36", HOLD_BUSY, 1);
        tick(1);
        check_eq("obst_activate_e37", Activate, 1);
        tick(1);
        base = act_cnt;
        OBST_RAW = 1'b1;
        tick(8);
        BTN_RAW = 1'b1;
        tick(10);
        BTN_RAW = 1'b0;
        tick(10);
        check_eq("obst_blocks_btn", act_cnt - base, 0);
        OBST_RAW = 1'b0;
        tick(8);
        UP_SW_RAW = 1'b0;
        tick(8);

        // 6: limit fault suppression, then reset in the middle of HOLDING
        base = act_cnt;
        UP_SW_RAW = 1'b1; DN_SW_RAW = 1'b1;
        tick(6);
        check_eq("fault_lim", LIM_FAULT, 1);
        BTN_RAW = 1'b1;
        tick(10);
        BTN_RAW = 1'b0;
        tick(30);
        check_eq("fault_no_activate", act_cnt - base, 0);
        check_eq("fault_no_hold", HOLD_BUSY, 0);
        DN_SW_RAW = 1'b0;
        tick(6);
        check_eq("fault_cleared", LIM_FAULT, 0);
        tick(1);
        check_eq("hold_after_fault", HOLD_BUSY, 1);
        tick(4);
        RST = 1'b0;
        #1;
        check_eq("midrst_up", UP_Max, 0);
        check_eq("midrst_busy", HOLD_BUSY, 0);
        check_eq("midrst_activate", Activate, 0);
        tick(3);
        check_eq("midrst_no_activate", act_cnt - base, 0);
        RST = 1'b1;
        tick(5);
        check_eq("rerise_edge5", UP_Max, 0);
        tick(1);
        check_eq("rerise_edge6", UP_Max, 1);
        tick(16);
        check_eq("rerise_no_early", act_cnt - base, 0);
        check_eq("rerise_busy", HOLD_BUSY, 1);
        tick(1);
        check_eq("rerise_activate", Activate, 1);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
